// File: rtl/rgb2gray_pkg.sv
// ----------------------------------------------------------------------------
// rgb2gray_pkg
// Shared definitions for the RGB-to-gray capture controller and its converter
// bench: controller state encoding, coordinate width and default frame size.
// ----------------------------------------------------------------------------
package rgb2gray_pkg;

    // Default active frame geometry (pixels per line, lines per frame).
    localparam int unsigned H_ACTIVE_DEF = 800;
    localparam int unsigned V_ACTIVE_DEF = 480;

    // Width of the X/Y coordinate buses handed to the converter.
    localparam int unsigned COORD_W = 16;

    // Capture controller states.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitSof = 2'd1,
        StActive  = 2'd2,
        StFinish  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/rgb2gray_pix_cnt.sv
// ----------------------------------------------------------------------------
// rgb2gray_pix_cnt
// X/Y pixel position counter for one frame. Tracks the coordinate the next
// valid pixel will take, wraps X at the end of a line, holds at the last
// pixel of the frame and flags any pixel that arrives after the frame is full.
//
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_clr     start of frame: restart at (0,0) and clear full/overflow; may be
//             combined with i_inc in the same cycle
//   i_inc     a valid pixel is offered this cycle
//   o_accept  the offered pixel lies inside the frame and should be forwarded
//   o_x, o_y  coordinate assigned to the offered pixel
//   o_full    every pixel of the frame has been counted
//   o_ovf     at least one pixel arrived after the frame was full
// ----------------------------------------------------------------------------
module rgb2gray_pix_cnt
    import rgb2gray_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_inc,
    output logic               o_accept,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_full,
    output logic               o_ovf
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_full;
    logic               r_ovf;

    // Starting point for this cycle: a start-of-frame clear takes effect
    // immediately so a pixel arriving together with the clear gets (0,0).
    logic [COORD_W-1:0] w_x_base;
    logic [COORD_W-1:0] w_y_base;
    logic               w_full_base;
    logic               w_ovf_base;

    logic [COORD_W-1:0] w_x_nxt;
    logic [COORD_W-1:0] w_y_nxt;
    logic               w_full_nxt;
    logic               w_ovf_nxt;

    always_comb begin
        w_x_base    = i_clr ? '0 : r_x;
        w_y_base    = i_clr ? '0 : r_y;
        w_full_base = i_clr ? 1'b0 : r_full;
        w_ovf_base  = i_clr ? 1'b0 : r_ovf;
    end

    always_comb begin
        w_x_nxt    = w_x_base;
        w_y_nxt    = w_y_base;
        w_full_nxt = w_full_base;
        w_ovf_nxt  = w_ovf_base;
        if (i_inc) begin
            if (w_full_base) begin
                // Frame already complete: pixel is dropped, position held.
                w_ovf_nxt = 1'b1;
            end else if (w_x_base == X_LAST) begin
                if (w_y_base == Y_LAST) begin
                    // Last pixel of the frame: hold at (X_LAST, Y_LAST).
                    w_full_nxt = 1'b1;
                end else begin
                    w_x_nxt = '0;
                    w_y_nxt = w_y_base + COORD_W'(1);
                end
            end else begin
                w_x_nxt = w_x_base + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_full <= w_full_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign o_accept = i_inc & ~w_full_base;
    assign o_x      = w_x_base;
    assign o_y      = w_y_base;
    assign o_full   = r_full;
    assign o_ovf    = r_ovf;

endmodule

// File: rtl/rgb2gray_ctrl.sv
// ----------------------------------------------------------------------------
// rgb2gray_ctrl
// Capture controller placed between a camera pixel stream and the RGB2GRAY
// converter. After a start request it waits for the next frame-valid rising
// edge, forwards valid pixels with registered X/Y coordinates, checks that the
// frame holds exactly H_ACTIVE*V_ACTIVE pixels and counts completed frames.
// Single-frame or continuous capture; continuous capture ends at the frame
// boundary following a stop request.
//
// Ports
//   iCLK        clock, rising edge
//   iReset_n    asynchronous active-low reset
//   iStart      one-cycle capture request, honoured only when idle
//   iMode       sampled with iStart: 0 single frame, 1 continuous
//   iStop       ends continuous capture at the next frame boundary
//   iFval       camera frame valid
//   iDval       camera pixel valid
//   oDval       pixel valid to converter (one cycle after iDval)
//   oX_Cont     column of the forwarded pixel
//   oY_Cont     line of the forwarded pixel
//   oBusy       high whenever not idle
//   oDone       one-cycle pulse at the end of each captured frame
//   oErr        sticky: a captured frame had the wrong pixel count
//   oFrame_Cnt  frames completed since the last accepted start
// ----------------------------------------------------------------------------
module rgb2gray_ctrl
    import rgb2gray_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               iCLK,
    input  logic               iReset_n,
    input  logic               iStart,
    input  logic               iMode,
    input  logic               iStop,
    input  logic               iFval,
    input  logic               iDval,
    output logic               oDval,
    output logic [COORD_W-1:0] oX_Cont,
    output logic [COORD_W-1:0] oY_Cont,
    output logic               oBusy,
    output logic               oDone,
    output logic               oErr,
    output logic [COORD_W-1:0] oFrame_Cnt
);

    ctrl_state_e r_state;
    logic        r_fval_d;
    logic        r_mode;
    logic        r_stop_req;

    logic               w_pix;
    logic               w_fval_rise;
    logic               w_fval_fall;
    logic               w_sof;
    logic               w_cnt_inc;
    logic               w_accept;
    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic               w_full;
    logic               w_ovf;

    assign w_pix       = iDval & iFval;
    assign w_fval_rise = iFval & ~r_fval_d;
    assign w_fval_fall = ~iFval & r_fval_d;

    // Start of a captured frame; a pixel on the rising-edge cycle is kept.
    assign w_sof     = (r_state == StWaitSof) & w_fval_rise;
    assign w_cnt_inc = w_pix & ((r_state == StActive) | w_sof);

    rgb2gray_pix_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pix_cnt (
        .i_clk    (iCLK),
        .i_rst_n  (iReset_n),
        .i_clr    (w_sof),
        .i_inc    (w_cnt_inc),
        .o_accept (w_accept),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_full   (w_full),
        .o_ovf    (w_ovf)
    );

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state    <= StIdle;
            r_fval_d   <= 1'b0;
            r_mode     <= 1'b0;
            r_stop_req <= 1'b0;
            oDval      <= 1'b0;
            oX_Cont    <= '0;
            oY_Cont    <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oErr       <= 1'b0;
            oFrame_Cnt <= '0;
        end else begin
            r_fval_d <= iFval;
            oDone    <= 1'b0;
            oDval    <= w_accept;
            if (w_accept) begin
                oX_Cont <= w_x;
                oY_Cont <= w_y;
            end

            unique case (r_state)
                StIdle: begin
                    if (iStart) begin
                        r_state    <= StWaitSof;
                        r_mode     <= iMode;
                        r_stop_req <= 1'b0;
                        oErr       <= 1'b0;
                        oFrame_Cnt <= '0;
                        oBusy      <= 1'b1;
                    end
                end
                StWaitSof: begin
                    // Stop is remembered so a short pulse still ends capture.
                    if (iStop) begin
                        r_stop_req <= 1'b1;
                    end
                    if (w_fval_rise) begin
                        r_state <= StActive;
                    end
                end
                StActive: begin
                    if (iStop) begin
                        r_stop_req <= 1'b1;
                    end
                    if (w_fval_fall) begin
                        r_state    <= StFinish;
                        oDone      <= 1'b1;
                        oFrame_Cnt <= oFrame_Cnt + COORD_W'(1);
                        if (w_ovf || !w_full) begin
                            oErr <= 1'b1;
                        end
                    end
                end
                StFinish: begin
                    if (r_mode && !iStop && !r_stop_req) begin
                        r_state <= StWaitSof;
                    end else begin
                        r_state <= StIdle;
                        oBusy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    oBusy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
